srff_count_ctrl: RTL

Controller that sequences a bank of WIDTH SR flip-flops as a loadable, modulo-MODULO up/down counter. Commands arrive over a valid/ready handshake. An FSM derives per-bit S/R drive from the current and next state, so S=R=1 is structurally impossible. The block is the reusable sequencer for SR-based counting datapaths. It follows the same conversion idea as SR-to-T, where each bit's S and R are computed from the present q and the desired next value.

---
 rtl/srff_count_ctrl_pkg.sv | 39 +++
 rtl/srff_count_ctrl_if.sv | 34 +++
 rtl/srff_count_ctrl_srff_ar.sv | 30 +++
 rtl/srff_count_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/srff_count_ctrl_pkg.sv
// +----------------------------------------------------------------------------
// | srff_ctrl_pkg : shared types and opcodes for the SR-bank counter controller
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package srff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN_UP = 2'd2,
    RUN_DN = 2'd3
  } state_t;

  typedef logic [1:0] op_t;

  localparam op_t OP_STOP = 2'b00;
  localparam op_t OP_LOAD = 2'b01;
  localparam op_t OP_UP   = 2'b10;
  localparam op_t OP_DN   = 2'b11;

  // Every accepted command selects the same destination state regardless of
  // which state accepted it; repeating the current run direction is a no-op.
  function automatic state_t cmd_to_state(input op_t op);
    state_t st;
    st = IDLE;
    case (op)
      OP_LOAD: st = LOAD;
      OP_UP:   st = RUN_UP;
      OP_DN:   st = RUN_DN;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/srff_count_ctrl_if.sv
// +----------------------------------------------------------------------------
// | srff_count_ctrl_if : valid/ready command channel for the SR counter
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface srff_count_ctrl_if
  import srff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/srff_count_ctrl_srff_ar.sv
// +----------------------------------------------------------------------------
// | srff_ar : single SR flip-flop, asynchronous active-low reset to 0
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module srff_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({s, r})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= 1'bx;
        default: q <= q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/srff_count_ctrl.sv
// +----------------------------------------------------------------------------
// | srff_count_ctrl : loadable modulo up/down counter built on an SR flip-flop bank
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module srff_count_ctrl
  import srff_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  srff_count_ctrl_if.slave cmd,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             sr_err
);

  // Compared one bit wider so MODULO == 2**WIDTH is representable.
  localparam logic [WIDTH-1:0] c_top = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   c_mod = (WIDTH + 1)'(MODULO);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] r_load;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_ready;
  logic             w_accept;
  logic             w_wrap_nxt;
  logic             r_wrap;
  logic             r_sr_err;

  assign w_ready    = (r_state != LOAD);
  assign w_accept   = cmd.cmd_valid & w_ready;
  assign w_load_sat = ({1'b0, cmd.cmd_data} >= c_mod) ? c_top : cmd.cmd_data;

  assign w_up = (w_q == c_top)     ? '0    : w_q + WIDTH'(1);
  assign w_dn = (w_q == '0)        ? c_top : w_q - WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_nxt       = w_q;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_nxt = w_q;
      end
      LOAD: begin
        w_nxt       = r_load;
        w_state_nxt = IDLE;
      end
      RUN_UP: begin
        w_nxt      = w_up;
        w_wrap_nxt = (w_q == c_top);
      end
      RUN_DN: begin
        w_nxt      = w_dn;
        w_wrap_nxt = (w_q == '0);
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // The accepting edge still performs the current state's step above.
    if (w_accept) begin
      w_state_nxt = cmd_to_state(cmd.cmd_op);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load <= '0;
    end else if (w_accept && (cmd.cmd_op == OP_LOAD)) begin
      r_load <= w_load_sat;
    end
  end

  // Drive only the bits that change; hold is s = r = 0.
  assign w_s = w_nxt & ~w_q;
  assign w_r = ~w_nxt & w_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
      srff_ar u_srff (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (w_s[i]),
        .r     (w_r[i]),
        .q     (w_q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap   <= 1'b0;
      r_sr_err <= 1'b0;
    end else begin
      r_wrap   <= w_wrap_nxt;
      r_sr_err <= r_sr_err | (|(w_s & w_r));
    end
  end

  assign cmd.cmd_ready = w_ready;
  assign q             = w_q;
  assign busy          = (r_state != IDLE);
  assign wrap          = r_wrap;
  assign sr_err        = r_sr_err;

endmodule

`default_nettype wire
